// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the board reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    REL_PERIPH,
    REL_CPU,
    RUN
  } seq_state_t;

  // Bit positions inside reset_cause.
  localparam int unsigned CAUSE_POR = 0;
  localparam int unsigned CAUSE_BTN = 1;
  localparam int unsigned CAUSE_SW  = 2;
  localparam int unsigned CAUSE_WDT = 3;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer with an optional stable-count debouncer.
// DEBOUNCE <= 1 gives the bare synchronized level; press is then its rising edge.
module sync_debounce #(
  parameter int unsigned DEBOUNCE = 1
) (
  input  logic clock48,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic press
);

  logic s1, s2;

  always_ff @(posedge clock48 or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  if (DEBOUNCE <= 1) begin : g_sync_only
    logic prev;

    always_ff @(posedge clock48 or negedge resetn) begin
      if (!resetn) prev <= 1'b0;
      else         prev <= s2;
    end

    assign level = s2;
    assign press = s2 & ~prev;
  end else begin : g_debounce
    localparam int unsigned W = $clog2(DEBOUNCE);
    logic [W-1:0] cnt;
    logic         lvl;
    logic         press_q;

    // Count consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts the count, so the counter tops out at DEBOUNCE-1.
    always_ff @(posedge clock48 or negedge resetn) begin
      if (!resetn) begin
        cnt     <= '0;
        lvl     <= 1'b0;
        press_q <= 1'b0;
      end else begin
        press_q <= 1'b0;
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (cnt == W'(DEBOUNCE - 1)) begin
          cnt     <= '0;
          lvl     <= s2;
          press_q <= s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign level = lvl;
    assign press = press_q;
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: merges reset sources and releases flash, peripherals, then CPU
// in order, keeping a sticky cause word for firmware.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned ASSERT_CLOCKS   = 64,
  parameter int unsigned STAGE_CLOCKS    = 800,
  parameter int unsigned DEBOUNCE_CLOCKS = 4800,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clock48,
  input  logic       resetn,
  input  logic       pll_locked,
  input  logic       button_n,
  input  logic       wdt_bite,
  input  logic       sw_reset_req,
  input  logic       cause_clr,
  output logic       flash_resetn,
  output logic       periph_resetn,
  output logic       cpu_resetn,
  output logic       seq_ready,
  output logic [3:0] reset_cause
);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             flash_nxt, periph_nxt, cpu_nxt, ready_nxt;
  logic [3:0]       cause_nxt, src;
  logic             lock_s, press_evt, lock_lost, take;
  logic             btn_held_unused, lock_press_unused;

  sync_debounce #(.DEBOUNCE(DEBOUNCE_CLOCKS)) u_button (
    .clock48 (clock48),
    .resetn  (resetn),
    .din     (~button_n),
    .level   (btn_held_unused),
    .press   (press_evt)
  );

  sync_debounce #(.DEBOUNCE(1)) u_pll (
    .clock48 (clock48),
    .resetn  (resetn),
    .din     (pll_locked),
    .level   (lock_s),
    .press   (lock_press_unused)
  );

  always_ff @(posedge clock48 or negedge resetn) begin
    if (!resetn) begin
      state         <= HOLD;
      cnt           <= '0;
      flash_resetn  <= 1'b0;
      periph_resetn <= 1'b0;
      cpu_resetn    <= 1'b0;
      seq_ready     <= 1'b0;
      reset_cause   <= 4'b0001;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      flash_resetn  <= flash_nxt;
      periph_resetn <= periph_nxt;
      cpu_resetn    <= cpu_nxt;
      seq_ready     <= ready_nxt;
      reset_cause   <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = (cnt == '1) ? cnt : cnt + 1'b1;
    flash_nxt  = flash_resetn;
    periph_nxt = periph_resetn;
    cpu_nxt    = cpu_resetn;
    ready_nxt  = seq_ready;

    lock_lost = ~lock_s & (state inside {REL_PERIPH, REL_CPU, RUN});
    src = '0;
    src[CAUSE_WDT] = wdt_bite;
    src[CAUSE_SW]  = sw_reset_req;
    src[CAUSE_BTN] = press_evt;
    src[CAUSE_POR] = lock_lost;
    // Everything is already held in WAIT_LOCK, so sources are not acted on there.
    take = (state != WAIT_LOCK) && (src != '0);

    if (take) begin
      state_nxt  = HOLD;
      cnt_nxt    = '0;
      flash_nxt  = 1'b0;
      periph_nxt = 1'b0;
      cpu_nxt    = 1'b0;
      ready_nxt  = 1'b0;
    end else begin
      case (state)
        HOLD: if (cnt == CNT_W'(ASSERT_CLOCKS - 1)) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
        WAIT_LOCK: if (lock_s) begin
          state_nxt = REL_PERIPH;
          cnt_nxt   = '0;
          flash_nxt = 1'b1;
        end
        REL_PERIPH: if (cnt == CNT_W'(STAGE_CLOCKS - 1)) begin
          state_nxt  = REL_CPU;
          cnt_nxt    = '0;
          periph_nxt = 1'b1;
        end
        REL_CPU: if (cnt == CNT_W'(STAGE_CLOCKS - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          cpu_nxt   = 1'b1;
          ready_nxt = 1'b1;
        end
        RUN: ;
        default: begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      endcase
    end

    cause_nxt = cause_clr ? '0 : reset_cause;
    if (take) cause_nxt = cause_nxt | src;
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short timing parameters.
module tb_reset_sequencer;

  logic       clock48 = 1'b0;
  logic       resetn, pll_locked, button_n, wdt_bite, sw_reset_req, cause_clr;
  logic       flash_resetn, periph_resetn, cpu_resetn, seq_ready;
  logic [3:0] reset_cause;
  logic [3:0] outs;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;
  int unsigned e      = 0;

  assign outs = {flash_resetn, periph_resetn, cpu_resetn, seq_ready};

  always #5 clock48 = ~clock48;

  reset_sequencer #(
    .ASSERT_CLOCKS   (4),
    .STAGE_CLOCKS    (8),
    .DEBOUNCE_CLOCKS (16),
    .CNT_W           (16)
  ) dut (
    .clock48       (clock48),
    .resetn        (resetn),
    .pll_locked    (pll_locked),
    .button_n      (button_n),
    .wdt_bite      (wdt_bite),
    .sw_reset_req  (sw_reset_req),
    .cause_clr     (cause_clr),
    .flash_resetn  (flash_resetn),
    .periph_resetn (periph_resetn),
    .cpu_resetn    (cpu_resetn),
    .seq_ready     (seq_ready),
    .reset_cause   (reset_cause)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the negedge that follows relative posedge k.
  task automatic to_edge(input int unsigned k);
    while (e < k) begin
      @(negedge clock48);
      e++;
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clock48);
  endtask

  task automatic clear_cause();
    cause_clr = 1'b1;
    step(1);
    cause_clr = 1'b0;
    step(1);
    check("cause cleared", reset_cause, 4'b0000);
  endtask

  // Expects resetn low and pll locked; releases it here (edge 0 is the previous posedge).
  task automatic cold_boot();
    check("por outs", outs, 4'b0000);
    check("por cause", reset_cause, 4'b0001);
    resetn = 1'b1;
    e = 0;
    to_edge(4);  check("boot e4", outs, 4'b0000);
    to_edge(5);  check("boot flash e5", outs, 4'b1000);
    to_edge(12); check("boot e12", outs, 4'b1000);
    to_edge(13); check("boot periph e13", outs, 4'b1100);
    to_edge(20); check("boot e20", outs, 4'b1100);
    to_edge(21); check("boot cpu e21", outs, 4'b1111);
    check("boot cause", reset_cause, 4'b0001);
  endtask

  initial begin
    resetn = 1'b0; pll_locked = 1'b1; button_n = 1'b1;
    wdt_bite = 1'b0; sw_reset_req = 1'b0; cause_clr = 1'b0;
    step(3);

    cold_boot();

    // Late lock; a watchdog pulse while waiting for lock is ignored.
    resetn = 1'b0; pll_locked = 1'b0;
    step(2);
    resetn = 1'b1;
    e = 0;
    to_edge(10); wdt_bite = 1'b1;
    to_edge(11); wdt_bite = 1'b0;
    to_edge(12);
    check("wait_lock wdt outs", outs, 4'b0000);
    check("wait_lock wdt cause", reset_cause, 4'b0001);
    to_edge(30); pll_locked = 1'b1;
    to_edge(32); check("late e32", outs, 4'b0000);
    to_edge(33); check("late flash e33", outs, 4'b1000);
    to_edge(40); check("late e40", outs, 4'b1000);
    to_edge(41); check("late periph e41", outs, 4'b1100);
    to_edge(48); check("late e48", outs, 4'b1100);
    to_edge(49); check("late cpu e49", outs, 4'b1111);

    // Watchdog in RUN.
    clear_cause();
    e = 0;
    wdt_bite = 1'b1;
    to_edge(1); wdt_bite = 1'b0;
    check("wdt outs", outs, 4'b0000);
    check("wdt cause", reset_cause, 4'b1000);
    to_edge(5);  check("wdt e5", outs, 4'b0000);
    to_edge(6);  check("wdt flash e6", outs, 4'b1000);
    to_edge(13); check("wdt e13", outs, 4'b1000);
    to_edge(14); check("wdt periph e14", outs, 4'b1100);
    to_edge(21); check("wdt e21", outs, 4'b1100);
    to_edge(22); check("wdt cpu e22", outs, 4'b1111);

    // Bouncy button, then held low.
    clear_cause();
    for (int unsigned i = 0; i < 8; i++) begin
      button_n = (i % 2 == 1);
      step(5);
    end
    check("bounce ignored", outs, 4'b1111);
    check("bounce cause", reset_cause, 4'b0000);
    e = 0;
    button_n = 1'b0;
    to_edge(18); check("btn e18", outs, 4'b1111);
    to_edge(19); check("btn reset e19", outs, 4'b0000);
    check("btn cause", reset_cause, 4'b0010);
    to_edge(39); check("btn e39", outs, 4'b1100);
    to_edge(40); check("btn cpu e40", outs, 4'b1111);
    to_edge(100); check("btn held no repeat", outs, 4'b1111);
    button_n = 1'b1;
    step(25);

    // Software request with a simultaneous clear: new bits only.
    e = 0;
    sw_reset_req = 1'b1; cause_clr = 1'b1;
    to_edge(1); sw_reset_req = 1'b0; cause_clr = 1'b0;
    check("sw outs", outs, 4'b0000);
    check("sw clr cause", reset_cause, 4'b0100);
    to_edge(16); check("sw rel_cpu e16", outs, 4'b1100);
    sw_reset_req = 1'b1; wdt_bite = 1'b1;
    to_edge(17); sw_reset_req = 1'b0; wdt_bite = 1'b0;
    check("dual outs", outs, 4'b0000);
    check("dual cause", reset_cause, 4'b1100);
    // Event during HOLD restarts the count.
    to_edge(18); sw_reset_req = 1'b1;
    to_edge(19); sw_reset_req = 1'b0;
    check("hold evt cause", reset_cause, 4'b1100);
    to_edge(22); check("hold restart e22", outs, 4'b0000);
    to_edge(24); check("hold restart flash e24", outs, 4'b1000);

    // Asynchronous board reset in REL_PERIPH.
    to_edge(27);
    #2 resetn = 1'b0;
    #1;
    check("async outs", outs, 4'b0000);
    check("async cause", reset_cause, 4'b0001);
    step(2);
    cold_boot();

    // PLL lock loss in RUN.
    clear_cause();
    e = 0;
    pll_locked = 1'b0;
    to_edge(2);  check("pll e2", outs, 4'b1111);
    to_edge(3);  check("pll loss e3", outs, 4'b0000);
    check("pll cause", reset_cause, 4'b0001);
    to_edge(12); check("pll wait e12", outs, 4'b0000);
    pll_locked = 1'b1;
    to_edge(14); check("pll relock e14", outs, 4'b0000);
    to_edge(15); check("pll relock flash e15", outs, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
